// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: FSM state encoding and program index width.
package seq_pkg;

    localparam int PROG_IDX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        RUN,
        REPORT,
        DONE,
        ERR
    } seq_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Per-program cycle counter: cleared on issue, advanced while the program runs,
// and flagging when it reaches the abort limit.
module cycle_timer #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          hit
);

    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller in front of the core: launches NPROG programs per start, times each
// req->ack interval, reports it on a one-cycle strobe and aborts on a missing ack.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NPROG   = 3,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 16'hFFF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  core_req,
    input  logic                  core_ack,
    output logic [PROG_IDX_W-1:0] prog_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  cyc_valid,
    output logic [CW-1:0]         cyc_count,
    output logic [PROG_IDX_W-1:0] cyc_prog
);

    localparam logic [CW-1:0]         LIMIT     = CW'(TIMEOUT);
    localparam logic [PROG_IDX_W-1:0] LAST_PROG = PROG_IDX_W'(NPROG - 1);

    seq_state_t            stateQ;
    seq_state_t            stateD;
    logic [PROG_IDX_W-1:0] progIdxD;
    logic [CW-1:0]         count;
    logic                  timerHit;
    logic                  timerClear;
    logic                  timerEnable;

    // The counter stops at the limit, so it can never pass TIMEOUT.
    assign timerClear  = (stateQ == ISSUE);
    assign timerEnable = ((stateQ == ARM) || ((stateQ == RUN) && !core_ack)) && !timerHit;

    cycle_timer #(
        .CW(CW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timerClear),
        .enable(timerEnable),
        .limit (LIMIT),
        .count (count),
        .hit   (timerHit)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns each signal and no latch is inferred.
        stateD   = stateQ;
        progIdxD = prog_idx;
        case (stateQ)
            IDLE, DONE, ERR: begin
                if (start) begin
                    stateD   = ISSUE;
                    progIdxD = '0;
                end
            end
            ISSUE:  stateD = ARM;
            // Timeout outranks a same-cycle ack; ARM waits out a stale ack.
            ARM: begin
                if (timerHit)      stateD = ERR;
                else if (!core_ack) stateD = RUN;
            end
            RUN: begin
                if (timerHit)     stateD = ERR;
                else if (core_ack) stateD = REPORT;
            end
            REPORT: begin
                if (prog_idx == LAST_PROG) begin
                    stateD = DONE;
                end else begin
                    stateD   = ISSUE;
                    progIdxD = prog_idx + PROG_IDX_W'(1);
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ      <= IDLE;
            prog_idx    <= '0;
            core_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cyc_valid   <= 1'b0;
            cyc_count   <= '0;
            cyc_prog    <= '0;
        end else begin
            stateQ      <= stateD;
            prog_idx    <= progIdxD;
            core_req    <= (stateD == ISSUE);
            busy        <= stateD inside {ISSUE, ARM, RUN, REPORT};
            done        <= (stateD == DONE);
            timeout_err <= (stateD == ERR);
            cyc_valid   <= (stateD == REPORT);
            if (stateD == REPORT) begin
                cyc_count <= count;
                cyc_prog  <= prog_idx;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a core model acks per scenario, expected reports
// come from req->ack arithmetic and a monitor compares every cyc_valid strobe.
module tb_prog_sequencer;
    import seq_pkg::*;

    localparam int NPROG   = 3;
    localparam int CW      = 16;
    localparam int TIMEOUT = 20;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  core_ack;
    logic                  core_req;
    logic [PROG_IDX_W-1:0] prog_idx;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;
    logic                  cyc_valid;
    logic [CW-1:0]         cyc_count;
    logic [PROG_IDX_W-1:0] cyc_prog;

    always #5 clk = ~clk;

    prog_sequencer #(
        .NPROG  (NPROG),
        .CW     (CW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_req   (core_req),
        .core_ack   (core_ack),
        .prog_idx   (prog_idx),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .cyc_valid  (cyc_valid),
        .cyc_count  (cyc_count),
        .cyc_prog   (cyc_prog)
    );

    // Core behaviour per program: ack high for cycles 1..stale after req, low until
    // cycle delay, high from then on (delay >= stale+2).
    typedef struct {
        int stale;
        int delay;
        int prog;
    } scn_t;

    typedef struct {
        int prog;
        int count;
    } exp_t;

    scn_t scnQ[$];
    exp_t sbQ[$];
    int   checks      = 0;
    int   passes      = 0;
    int   reqCount    = 0;
    int   reportCount = 0;
    int   lastRep     = 0;
    int   seqStale[NPROG];
    int   seqDelay[NPROG];

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Core model and scoreboard producer.
    int   coreK = -1;
    scn_t coreCur;
    always @(negedge clk) begin
        if (reset) begin
            coreK    = -1;
            core_ack = 1'b0;
        end else if (core_req) begin
            reqCount++;
            check("program pending at core_req", scnQ.size() > 0, 1);
            if (scnQ.size() > 0) coreCur = scnQ.pop_front();
            else coreCur = '{stale: 0, delay: 100000, prog: -1};
            coreK = 0;
            // Ack first seen in RUN at req+delay, so the count is delay-1 unless the limit is hit first.
            if (coreCur.delay - 1 < TIMEOUT) sbQ.push_back('{prog: coreCur.prog, count: coreCur.delay - 1});
        end else if (coreK >= 0) begin
            coreK++;
            core_ack = (coreK <= coreCur.stale) || (coreK >= coreCur.delay);
        end
    end

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cyc_valid) begin : mon
            exp_t e;
            reportCount++;
            check("report expected", sbQ.size() > 0, 1);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check("cyc_prog", cyc_prog, e.prog);
                check("cyc_count", cyc_count, e.count);
            end
        end
    end

    task automatic runSeq(input string tag, input bit spam);
        int errProg = -1;
        int launched;
        int expLat = 0;
        int reqs0;
        int reps0;
        int n = 0;
        for (int i = 0; i < NPROG; i++) begin
            scnQ.push_back('{stale: seqStale[i], delay: seqDelay[i], prog: i});
            if (errProg < 0) begin
                if (seqDelay[i] - 1 >= TIMEOUT) begin
                    errProg = i;
                    expLat += TIMEOUT + 2;
                end else begin
                    expLat += seqDelay[i] + 2;
                end
            end
        end
        launched = (errProg < 0) ? NPROG : errProg + 1;
        reqs0 = reqCount;
        reps0 = reportCount;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " issue core_req"}, core_req, 1);
        check({tag, " issue busy"}, busy, 1);
        check({tag, " issue done"}, done, 0);
        check({tag, " issue timeout_err"}, timeout_err, 0);
        check({tag, " issue prog_idx"}, prog_idx, 0);
        check({tag, " cyc_count held"}, cyc_count, lastRep);
        while (!(done || timeout_err) && n < 3000) begin
            if (spam) start = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, " finished within budget"}, n < 3000, 1);
        check({tag, " latency"}, n, expLat);
        check({tag, " done"}, done, errProg < 0);
        check({tag, " timeout_err"}, timeout_err, errProg >= 0);
        check({tag, " busy low"}, busy, 0);
        if (errProg >= 0) check({tag, " failing prog_idx"}, prog_idx, errProg);
        check({tag, " core_req pulses"}, reqCount - reqs0, launched);
        check({tag, " reports"}, reportCount - reps0, launched - (errProg >= 0 ? 1 : 0));
        check({tag, " scoreboard drained"}, sbQ.size(), 0);
        scnQ.delete();
        for (int i = 0; i < launched; i++) begin
            if (seqDelay[i] - 1 < TIMEOUT) lastRep = seqDelay[i] - 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int reqs0;
        reset = 1'b1;
        start = 1'b0;
        core_ack = 1'b0;
        repeat (3) tick();
        check("reset core_req", core_req, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset timeout_err", timeout_err, 0);
        check("reset cyc_valid", cyc_valid, 0);
        check("reset cyc_count", cyc_count, 0);
        check("reset prog_idx", prog_idx, 0);
        reset = 1'b0;
        tick();

        // Plain run: ack 8 cycles after each req.
        seqStale = '{0, 0, 0};
        seqDelay = '{8, 8, 8};
        runSeq("basic", 1'b0);

        // Relaunch from DONE with a stale ack on program 0.
        seqStale = '{4, 0, 2};
        seqDelay = '{8, 3, 9};
        runSeq("stale", 1'b0);

        // Core never acks: abort on program 0, then a rerun clears the error.
        seqStale = '{0, 0, 0};
        seqDelay = '{100000, 8, 8};
        runSeq("timeout0", 1'b0);

        // Limit boundary: one below reports, exactly at the limit the ack loses to the timeout.
        seqStale = '{0, 3, 0};
        seqDelay = '{TIMEOUT, TIMEOUT + 1, 5};
        runSeq("boundary", 1'b0);

        seqStale = '{1, 0, 0};
        seqDelay = '{4, 2, TIMEOUT - 1};
        runSeq("spam", 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NPROG; i++) begin
                seqStale[i] = int'($urandom_range(0, 5));
                seqDelay[i] = int'($urandom_range(seqStale[i] + 2, 22));
            end
            runSeq($sformatf("rand%0d", r), r[0]);
        end

        // Reset during RUN of program 1, with start asserted on the same cycle.
        seqStale = '{0, 0, 0};
        seqDelay = '{8, 15, 8};
        for (int i = 0; i < NPROG; i++) scnQ.push_back('{stale: 0, delay: seqDelay[i], prog: i});
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(prog_idx == 1 && core_req) && n < 200) begin
            tick();
            n++;
        end
        check("midreset reached program 1", prog_idx == 1 && core_req, 1);
        repeat (3) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("midreset core_req", core_req, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset timeout_err", timeout_err, 0);
        check("midreset cyc_valid", cyc_valid, 0);
        check("midreset prog_idx", prog_idx, 0);
        check("midreset cyc_prog", cyc_prog, 0);
        check("midreset cyc_count", cyc_count, 0);
        reset = 1'b0;
        start = 1'b0;
        scnQ.delete();
        sbQ.delete();
        lastRep = 0;
        reqs0 = reqCount;
        repeat (10) tick();
        check("idle after reset: busy", busy, 0);
        check("idle after reset: no core_req", reqCount - reqs0, 0);

        seqStale = '{2, 0, 1};
        seqDelay = '{6, 11, 4};
        runSeq("after_reset", 1'b0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
